// File: rtl/ps2_kbd_rx_if.sv
// -----------------------------------------------------------------------------
// ps2_kbd_rx_if
// Keyboard port on the MIO bus (0xd0000000).
//   ps2_rdn       : active-low read/pop strobe from the bus (bus -> receiver)
//   ps2_data[7:0] : FIFO head byte, 8'h00 when empty (receiver -> bus)
//   ps2_ready     : FIFO non-empty (receiver -> bus)
//   ps2_overflow  : sticky byte-dropped flag, clears on the next pop
//   ps2_frame_err : one-cycle pulse on a parity/stop error
// master = bus side, slave = keyboard receiver.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface ps2_kbd_rx_if;
  logic       ps2_rdn;
  logic [7:0] ps2_data;
  logic       ps2_ready;
  logic       ps2_overflow;
  logic       ps2_frame_err;

  modport master (
    output ps2_rdn,
    input  ps2_data, ps2_ready, ps2_overflow, ps2_frame_err
  );

  modport slave (
    input  ps2_rdn,
    output ps2_data, ps2_ready, ps2_overflow, ps2_frame_err
  );
endinterface

// File: rtl/ps2_kbd_rx.sv
// -----------------------------------------------------------------------------
// ps2_kbd_rx
// PS/2 keyboard receiver. Synchronises the raw PS/2 clock/data pins into clk,
// deframes 11-bit device-to-host frames (start, 8 data LSB-first, odd parity,
// stop), and queues good bytes in a small FIFO read through the MIO bus port.
// Ports:
//   clk      : system clock, rising edge
//   rst      : asynchronous active-high reset
//   ps2_clk  : raw PS/2 clock pin (asynchronous)
//   ps2_dat  : raw PS/2 data pin (asynchronous)
//   bus      : keyboard bus port (slave side), see ps2_kbd_rx_if
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module ps2_kbd_rx #(
  parameter int FIFO_AW = 3,
  parameter int TIMEOUT = 5000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ps2_clk,
  input  logic          ps2_dat,
  ps2_kbd_rx_if.slave   bus
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Pin synchronisers; reset to the idle-high bus level so that leaving
  // reset never looks like a falling edge.
  logic clk_s1_q, clk_s2_q, clk_hist_q;
  logic dat_s1_q, dat_s2_q;

  logic fall;
  logic bit_in;

  state_t          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            frame_err_q, frame_err_d;
  logic            push;

  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       mem [DEPTH];
  logic             empty, full, pop, wr_en;

  assign fall   = clk_hist_q & ~clk_s2_q;
  assign bit_in = dat_s2_q;

  // ---------------------------------------------------------------------------
  // Deframer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    tmo_d       = tmo_q;
    frame_err_d = 1'b0;
    push        = 1'b0;

    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (fall && !bit_in) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
        end
      end
      DATA: begin
        if (fall) begin
          shift_d   = {bit_in, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          parity_d = bit_in;
          state_d  = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          // Odd parity: data bits plus parity bit must hold an odd number of ones.
          if (bit_in && ((^shift_q) ^ parity_q)) push = 1'b1;
          else                                   frame_err_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Inactivity watchdog for partial frames; an abandoned frame is silent.
    if (state_q != IDLE) begin
      if (fall) begin
        tmo_d = '0;
      end else if (tmo_q == TW'(TIMEOUT)) begin
        tmo_d   = '0;
        state_d = IDLE;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                 (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign pop   = ~bus.ps2_rdn & ~empty;
  // A full FIFO still accepts a push when the same cycle pops the head.
  assign wr_en = push & (~full | pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + (FIFO_AW+1)'(wr_en);
    rd_ptr_d = rd_ptr_q + (FIFO_AW+1)'(pop);
    ovf_d    = ovf_q;
    if (push && full && !pop) ovf_d = 1'b1;
    else if (pop)             ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      clk_hist_q  <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      parity_q    <= 1'b0;
      tmo_q       <= '0;
      frame_err_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ovf_q       <= 1'b0;
    end else begin
      clk_s1_q    <= ps2_clk;
      clk_s2_q    <= clk_s1_q;
      clk_hist_q  <= clk_s2_q;
      dat_s1_q    <= ps2_dat;
      dat_s2_q    <= dat_s1_q;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      tmo_q       <= tmo_d;
      frame_err_q <= frame_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ovf_q       <= ovf_d;
    end
  end

  // Storage carries no reset; validity comes from the pointers alone.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[FIFO_AW-1:0]] <= shift_q;
  end

  // Outputs depend only on registered FIFO state, never on ps2_rdn.
  assign bus.ps2_ready     = ~empty;
  assign bus.ps2_data      = empty ? 8'h00 : mem[rd_ptr_q[FIFO_AW-1:0]];
  assign bus.ps2_overflow  = ovf_q;
  assign bus.ps2_frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
`timescale 1ns/1ps
module tb_ps2_kbd_rx;
  localparam int HALF = 20;     // clk cycles per PS/2 clock phase (scaled rate)
  localparam int TMO  = 5000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_dat = 1'b1;

  ps2_kbd_rx_if bus ();

  ps2_kbd_rx #(.FIFO_AW(3), .TIMEOUT(TMO)) dut (
    .clk     (clk),
    .rst     (rst),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int err_pulses = 0;

  always @(posedge clk) if (bus.ps2_frame_err === 1'b1) err_pulses++;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Frame bits in line order: start, d0..d7, parity, stop.
  function automatic logic [10:0] frame(input logic [7:0] d, input logic good_par);
    logic p;
    p = ~^d;
    if (!good_par) p = ~p;
    return {1'b1, p, d, 1'b0};
  endfunction

  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b1;
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) ps2_bit(f[i]);
  endtask

  task automatic send_frame(input logic [7:0] d);
    send_bits(frame(d, 1'b1), 11);
    $display("frame %h sent", d);
  endtask

  task automatic pop1(output logic [7:0] popped);
    popped = bus.ps2_data;
    bus.ps2_rdn = 1'b0;
    @(posedge clk);
    #1 bus.ps2_rdn = 1'b1;
    $display("pop read %h", popped);
  endtask

  // Stop bit with cycle-accurate sampling around the detected fall.
  task automatic stop_edge(input logic pop_now, output logic rdy_fall, output logic rdy_after,
                           output logic err_after, output logic err_next, output logic [7:0] dat_after);
    ps2_dat = 1'b1;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rdy_fall = bus.ps2_ready;          // this is the fall-detect cycle
    if (pop_now) bus.ps2_rdn = 1'b0;
    @(posedge clk);
    #1 bus.ps2_rdn = 1'b1;
    rdy_after = bus.ps2_ready;
    err_after = bus.ps2_frame_err;
    dat_after = bus.ps2_data;
    @(posedge clk);
    #1 err_next = bus.ps2_frame_err;
    repeat (HALF - 3) @(posedge clk);
    #1 ps2_clk = 1'b1;
    $display("stop bit sent (pop=%0b)", pop_now);
  endtask

  logic       rf, ra, ea, en;
  logic [7:0] da, pv;
  int         e0;
  logic [10:0] f;

  initial begin
    bus.ps2_rdn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", bus.ps2_ready, 8'h00);
    chk("rst_data", bus.ps2_data, 8'h00);
    chk("rst_ovf", bus.ps2_overflow, 8'h00);
    chk("rst_err", bus.ps2_frame_err, 8'h00);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Good 0x1B frame, exact push latency, then a single pop.
    send_bits(frame(8'h1B, 1'b1), 10);
    stop_edge(1'b0, rf, ra, ea, en, da);
    chk("t1_ready_in_fall_cycle", rf, 8'h00);
    chk("t1_ready_after", ra, 8'h01);
    chk("t1_data_after", da, 8'h1B);
    chk("t1_no_err", ea, 8'h00);
    pop1(pv);
    chk("t1_ready_popped", bus.ps2_ready, 8'h00);
    chk("t1_data_popped", bus.ps2_data, 8'h00);

    // Bad parity, then a good 0xF0.
    e0 = err_pulses;
    send_bits(frame(8'h1B, 1'b0), 10);
    stop_edge(1'b0, rf, ra, ea, en, da);
    chk("t2_err_pulse", ea, 8'h01);
    chk("t2_err_cleared", en, 8'h00);
    chk("t2_ready_stays0", ra, 8'h00);
    chk("t2_err_count", 8'(err_pulses - e0), 8'h01);
    send_frame(8'hF0);
    chk("t2_ready_f0", bus.ps2_ready, 8'h01);
    chk("t2_data_f0", bus.ps2_data, 8'hF0);
    pop1(pv);

    // Overflow on the ninth byte; drain eight in order.
    for (int i = 1; i <= 8; i++) send_frame(8'(i));
    chk("t3_ovf_before", bus.ps2_overflow, 8'h00);
    chk("t3_ready_full", bus.ps2_ready, 8'h01);
    send_frame(8'h09);
    chk("t3_ovf_set", bus.ps2_overflow, 8'h01);
    for (int i = 1; i <= 8; i++) begin
      pop1(pv);
      chk("t3_pop_order", pv, 8'(i));
      if (i == 1) chk("t3_ovf_clear", bus.ps2_overflow, 8'h00);
    end
    chk("t3_ready_drained", bus.ps2_ready, 8'h00);
    chk("t3_data_drained", bus.ps2_data, 8'h00);

    // Partial frame abandoned by timeout, then a clean 0x1C.
    e0 = err_pulses;
    send_bits(frame(8'h55, 1'b1), 5);
    ps2_dat = 1'b1;
    repeat (TMO + 10) @(posedge clk);
    #1;
    chk("t4_nothing_queued", bus.ps2_ready, 8'h00);
    send_frame(8'h1C);
    chk("t4_ready", bus.ps2_ready, 8'h01);
    chk("t4_data", bus.ps2_data, 8'h1C);
    pop1(pv);
    chk("t4_single_byte", bus.ps2_ready, 8'h00);
    chk("t4_no_err", 8'(err_pulses - e0), 8'h00);

    // Push coinciding with a pop.
    send_frame(8'h3A);
    chk("t5_first", bus.ps2_data, 8'h3A);
    send_bits(frame(8'h4B, 1'b1), 10);
    stop_edge(1'b1, rf, ra, ea, en, da);
    chk("t5_ready_in_fall", rf, 8'h01);
    chk("t5_ready_after", ra, 8'h01);
    chk("t5_data_second", da, 8'h4B);
    pop1(pv);
    chk("t5_ready_empty", bus.ps2_ready, 8'h00);

    // Reset mid-frame with two bytes queued.
    send_frame(8'h11);
    send_frame(8'h22);
    chk("t6_queued", bus.ps2_data, 8'h11);
    f = frame(8'h5A, 1'b1);
    send_bits(f, 5);
    ps2_dat = f[5];
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_ready", bus.ps2_ready, 8'h00);
    chk("t6_rst_data", bus.ps2_data, 8'h00);
    chk("t6_rst_ovf", bus.ps2_overflow, 8'h00);
    chk("t6_rst_err", bus.ps2_frame_err, 8'h00);
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    $display("reset pulse applied mid-frame");
    repeat (5) @(posedge clk);
    #1;
    send_frame(8'h29);
    chk("t6_ready_29", bus.ps2_ready, 8'h01);
    chk("t6_data_29", bus.ps2_data, 8'h29);
    pop1(pv);
    chk("t6_ready_end", bus.ps2_ready, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/ps2_kbd_rx.md
Name: ps2_kbd_rx

Overview:
PS/2 keyboard receiver feeding the MIO bus keyboard port at 0xd0000000. Samples the raw PS/2 clock/data pins in the system clock domain and deframes 11-bit device-to-host frames. Buffers valid scan-code bytes in a small FIFO. Presents the head byte as ps2_data and non-empty as ps2_ready, and pops one byte per bus read strobe ps2_rdn.

Parameters:
FIFO_AW, 3, log2 of FIFO depth (depth 8)
TIMEOUT, 5000, clk cycles without a PS/2 falling edge before a partial frame is abandoned

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
ps2_clk  input  1  raw PS/2 clock pin (asynchronous)
ps2_dat  input  1  raw PS/2 data pin (asynchronous)
ps2_rdn  input  1  active-low read/pop strobe from MIO bus
ps2_data  output  8  FIFO head byte; 8'h00 when empty
ps2_ready  output  1  FIFO non-empty
ps2_overflow  output  1  sticky: a valid byte was dropped because the FIFO was full
ps2_frame_err  output  1  one-cycle pulse on parity/stop error

Behaviour:
- Reset (async, rst=1): FSM=IDLE, bit count 0, timeout counter 0, FIFO empty, both pointers 0. Outputs ps2_data=00, ps2_ready=0, ps2_overflow=0, ps2_frame_err=0. Reset mid-frame discards the partial frame.
- Sync: ps2_clk and ps2_dat each pass through 2 flops, followed by a 1-flop history on clk. A fall pulse fires for one cycle when history=1 and synced=0. Data is sampled as the synced ps2_dat in the fall cycle.
- FSM:
  - IDLE: on fall with dat=0 (start bit) go to DATA and clear the bit count. On fall with dat=1, stay in IDLE.
  - DATA: on each fall, shift dat in LSB-first. After 8 bits, go to PARITY.
  - PARITY: on fall, store the parity bit and go to STOP.
  - STOP: on fall, the frame is good if dat=1 and (XOR of 8 data bits ^ parity)=1 (odd parity). A good frame is pushed. A bad frame pulses ps2_frame_err in the following cycle. Go to IDLE either way.
- Timeout: in DATA/PARITY/STOP, the counter increments each cycle without a fall and clears on a fall. When it reaches TIMEOUT, return to IDLE, discard the frame, and raise no error. The counter is held at 0 in IDLE.
- Push latency: the FIFO is written on the clk edge ending the cycle in which the stop-bit fall is detected. ps2_ready=1 and ps2_data valid from the next cycle.
- Pop: each clk cycle with ps2_rdn=0 and ps2_ready=1 pops one entry. ps2_rdn held low N cycles pops up to N entries. Pop while empty is ignored.
- Full: a push when count=DEPTH and no pop in the same cycle drops the byte and sets ps2_overflow=1. A push plus pop in the same cycle when full is accepted, and the count stays at DEPTH.
- Push+pop in the same cycle on a non-empty FIFO: the count is unchanged and ordering is preserved.
- ps2_overflow clears on the first pop after it is set, or on reset.
- FIFO: pointers of width FIFO_AW+1 wrap naturally. Empty when pointers are equal. Full when the MSBs differ and the low bits are equal.
- ps2_data/ps2_ready are registered and combinational only from FIFO state, with no dependency on ps2_rdn in the same cycle.

Test Plan:
- Drive frame 0x1B at a 12 kHz PS/2 clock: bits 0,1,1,0,1,1,0,0,0,parity=1,stop=1 -> ps2_ready=1, ps2_data=8'h1B one clk after the stop fall. Hold ps2_rdn=0 one cycle -> ps2_ready=0, ps2_data=8'h00.
- Frame 0x1B with parity=0 -> ps2_frame_err single-cycle pulse, ps2_ready stays 0. Then a good 0xF0 frame (parity 1) -> ps2_data=8'hF0.
- Nine good frames 0x01..0x09 with no reads -> ps2_overflow=1 after the 9th. Eight single-cycle pops return 01..08 in order, overflow clears on the first pop, and ps2_ready=0 after the 8th.
- Start bit plus 4 data bits, then stall ps2_clk for TIMEOUT+10 cycles, then a full frame 0x1C -> exactly one byte 8'h1C, no frame_err.
- One byte queued; a second frame's stop edge coincides with a ps2_rdn=0 cycle -> the first byte is popped, ps2_data shows the second byte, and ps2_ready stays 1.
- Assert rst during the 5th data bit with 2 bytes queued -> all outputs 0 immediately. A subsequent 0x29 frame is received correctly.
